track_sensor_conditioner: RTL and testbench
===========================================

Name: track_sensor_conditioner

Overview:
- Sits between the raw track phototransistor pins and the SoC motor-control inputs: `motor_control_0_external_sensorsignal` and `motor_control_0_external_roundsignal`.
- Synchronises and debounces the segment sensor and the start/finish sensor, then drives clean active-high levels into the SoC.
- Measures the lap time in clk cycles between accepted start/finish crossings and counts laps for software readout.

Parameters:
- DEBOUNCE_CYCLES, 500, consecutive stable synchronised samples required before a debounced level changes (≥1).
- MIN_LAP_CYCLES, 50000000, lockout: round edges closer than this to the previous accepted edge are ignored.
- LAP_W, 32, width of the lap timer and of lap_time.
- CNT_W, 16, width of lap_count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- seg_sensor_raw_n  in  1  raw segment sensor, active-low, asynchronous to clk.
- round_sensor_raw_n  in  1  raw start/finish sensor, active-low, asynchronous to clk.
- lap_clear  in  1  synchronous pulse; discards the timing reference and zeroes the counters.
- sensorsignal  out  1  debounced segment sensor, 1 = car present.
- roundsignal  out  1  debounced start/finish sensor, 1 = car present.
- round_pulse  out  1  one-cycle strobe on every accepted round edge.
- lap_valid  out  1  one-cycle strobe when lap_time/lap_count are updated.
- lap_time  out  LAP_W  cycles between the last two accepted round edges.
- lap_count  out  CNT_W  completed laps since reset/clear; wraps modulo 2^CNT_W.
- lap_overflow  out  1  sticky; set when a lap exceeded 2^LAP_W-1 cycles.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - Synchronisers are preset to 1 (idle, raw inactive), so debounced levels start at 0.
  - FSM is in WAIT_FIRST.
- Synchronisation: each raw input passes through a 2-FF synchroniser and is then inverted, giving 1 = car present.
- Debounce, per channel:
  - A counter is cleared whenever the synchronised value equals the debounced value.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the mismatch still holds, the debounced value toggles and the counter clears.
  - A raw level held stable is therefore reflected on the output exactly 2+DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
  - Any bounce shorter than DEBOUNCE_CYCLES samples produces no output change.
- Edge detect: a rising edge is roundsignal going 0→1 (registered compare).
- Lap timer:
  - Increments every cycle while in TIMING.
  - Saturates at 2^LAP_W-1 and does not wrap.
- FSM:
  - WAIT_FIRST, on round edge: go to TIMING; timer ← 0; round_pulse=1; lap_valid=0; lap_count unchanged.
  - TIMING, on round edge with elapsed ≥ MIN_LAP_CYCLES:
    - round_pulse=1 and lap_valid=1, both in the same cycle.
    - lap_time ← elapsed cycles since the previous accepted edge (saturated value if saturated).
    - lap_count ← lap_count+1.
    - lap_overflow ← 1 if saturated.
    - timer restarts from 0.
  - TIMING, on round edge with elapsed < MIN_LAP_CYCLES: edge ignored; no strobes; timer continues.
  - Any state, lap_clear: go to WAIT_FIRST; timer, lap_time, lap_count and lap_overflow ← 0.
    - lap_clear wins over a coincident round edge, which is discarded.
    - Debounce state is not affected by lap_clear.
- Timing of updates: lap_time, lap_count and lap_overflow update in the same cycle lap_valid is high, and hold until the next update or clear.
- sensorsignal has no influence on lap timing; it is passed through only.

Decomposition:
- Shared package carrera_sensor_pkg holds:
  - the FSM state encoding (WAIT_FIRST, TIMING);
  - default constants for DEBOUNCE_CYCLES and MIN_LAP_CYCLES at 50 MHz.
- One sub-module, sensor_debounce: 2-FF sync, inversion and debounce counter, parameterised by DEBOUNCE_CYCLES. It is instantiated twice.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, MIN_LAP_CYCLES=20, LAP_W=8, CNT_W=4.
1. Reset checks: hold reset_n=0 with raw inputs=0 → all outputs 0. Release reset, hold round_sensor_raw_n=0 → roundsignal=1 exactly 6 cycles later; round_pulse fires once; lap_valid stays 0.
2. Debounce rejection: toggle seg_sensor_raw_n with 3-cycle-wide glitches → sensorsignal stays 0. Then hold low for 10 cycles → sensorsignal=1 six cycles after hold start.
3. Lap measurement: produce accepted round edges 50 cycles apart → lap_valid one cycle, lap_time=50, lap_count=1. A second lap of 37 cycles → lap_time=37, lap_count=2.
4. Lockout: after an accepted edge, a new edge at 10 cycles → no round_pulse and no lap_valid. The next edge at 60 cycles after the accepted edge → lap_time=60.
5. Saturation and wrap:
   - Edges 300 cycles apart → lap_time=255 and lap_overflow=1, which stays set on the following normal lap.
   - 17 valid laps → lap_count wraps to 1.
6. Clear and async reset:
   - lap_clear coincident with a round edge → state WAIT_FIRST; lap_count=0; no lap_valid. The next edge only re-arms the timer.
   - Async reset asserted mid-lap → all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/carrera_sensor_pkg.sv
// carrera_sensor_pkg
//   Items shared by the track sensor conditioner and its debounce sub-module:
//   - lap_state_e         : state encoding of the lap measurement FSM
//   - DEBOUNCE_CYCLES_DEF : default debounce length for a 50 MHz clock (10 us)
//   - MIN_LAP_CYCLES_DEF  : default minimum lap time for a 50 MHz clock (1 s)
package carrera_sensor_pkg;

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,  // no timing reference yet; the next round edge arms the timer
        TIMING     = 1'b1   // timer running since the last accepted round edge
    } lap_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd500;
    localparam int unsigned MIN_LAP_CYCLES_DEF  = 32'd50_000_000;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce
//   Brings one active-low phototransistor input into the clk domain and removes
//   contact/optical bounce.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset
//     raw_n  in  raw sensor pin, active-low, asynchronous to clk
//     level  out debounced level, 1 = car present (registered)
//   A stable raw level becomes visible on level DEBOUNCE_CYCLES+1 edges after
//   the first edge that samples it (2 synchroniser stages + counter).
module sensor_debounce
    import carrera_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level
);

    localparam int unsigned CNT_BITS = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 32'd1);

    logic                sync1_r;
    logic                sync2_r;
    logic                level_r;
    logic                present_s;
    logic                mismatch_s;
    logic [CNT_BITS-1:0] cnt_r;

    // Inverting after the synchroniser keeps the flops at the pin's idle level.
    assign present_s  = ~sync2_r;
    assign mismatch_s = present_s ^ level_r;
    assign level      = level_r;

    // Two-stage synchroniser, preset to the inactive (high) raw level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= raw_n;
            sync2_r <= sync1_r;
        end
    end

    // Stability counter: any agreeing sample restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_BITS{1'b0}};
            level_r <= 1'b0;
        end else if (!mismatch_s) begin
            cnt_r   <= {CNT_BITS{1'b0}};
            level_r <= level_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CNT_BITS{1'b0}};
            level_r <= ~level_r;
        end else begin
            cnt_r   <= cnt_r + CNT_BITS'(1'b1);
            level_r <= level_r;
        end
    end

endmodule

// File: rtl/track_sensor_conditioner.sv
// track_sensor_conditioner
//   Conditions the segment and start/finish phototransistors for the SoC
//   motor-control block and measures lap times.
//   Ports:
//     clk                in  system clock
//     reset_n            in  asynchronous active-low reset
//     seg_sensor_raw_n   in  raw segment sensor, active-low, asynchronous
//     round_sensor_raw_n in  raw start/finish sensor, active-low, asynchronous
//     lap_clear          in  synchronous pulse: drop timing reference, zero lap results
//     sensorsignal       out debounced segment sensor, 1 = car present
//     roundsignal        out debounced start/finish sensor, 1 = car present
//     round_pulse        out one-cycle strobe per accepted round edge
//     lap_valid          out one-cycle strobe when lap_time/lap_count update
//     lap_time           out cycles between the last two accepted round edges (saturating)
//     lap_count          out completed laps since reset/clear, wraps
//     lap_overflow       out sticky: a lap exceeded the lap_time range
//   All outputs are registered; round_pulse rises in the same cycle as roundsignal.
module track_sensor_conditioner
    import carrera_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned MIN_LAP_CYCLES  = MIN_LAP_CYCLES_DEF,
    parameter int unsigned LAP_W           = 32'd32,
    parameter int unsigned CNT_W           = 32'd16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             seg_sensor_raw_n,
    input  logic             round_sensor_raw_n,
    input  logic             lap_clear,
    output logic             sensorsignal,
    output logic             roundsignal,
    output logic             round_pulse,
    output logic             lap_valid,
    output logic [LAP_W-1:0] lap_time,
    output logic [CNT_W-1:0] lap_count,
    output logic             lap_overflow
);

    localparam logic [LAP_W-1:0] TIMER_MAX = {LAP_W{1'b1}};

    logic             seg_level_s;
    logic             round_level_s;
    logic             round_edge_s;
    logic             saturated_s;
    logic             lap_long_s;
    logic [LAP_W-1:0] elapsed_s;

    lap_state_e       state_r;
    logic [LAP_W-1:0] timer_r;
    logic             sensorsignal_r;
    logic             roundsignal_r;
    logic             round_pulse_r;
    logic             lap_valid_r;
    logic [LAP_W-1:0] lap_time_r;
    logic [CNT_W-1:0] lap_count_r;
    logic             lap_overflow_r;

    lap_state_e       state_nxt_s;
    logic [LAP_W-1:0] timer_nxt_s;
    logic             round_pulse_nxt_s;
    logic             lap_valid_nxt_s;
    logic [LAP_W-1:0] lap_time_nxt_s;
    logic [CNT_W-1:0] lap_count_nxt_s;
    logic             lap_overflow_nxt_s;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_seg_debounce (
        .clk   (clk),
        .rst_n (reset_n),
        .raw_n (seg_sensor_raw_n),
        .level (seg_level_s)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_round_debounce (
        .clk   (clk),
        .rst_n (reset_n),
        .raw_n (round_sensor_raw_n),
        .level (round_level_s)
    );

    // roundsignal_r is the registered copy of the debounced level, so comparing
    // against it yields exactly one edge cycle per car arrival.
    assign round_edge_s = round_level_s & ~roundsignal_r;

    // timer_r holds (cycles since reference - 1); elapsed_s is the lap length if
    // an edge is accepted at the coming clock edge. Once the timer is pinned at
    // its maximum the lap is known to be out of range.
    assign saturated_s = (timer_r == TIMER_MAX);
    assign elapsed_s   = saturated_s ? timer_r : (timer_r + LAP_W'(1'b1));
    assign lap_long_s  = (64'(elapsed_s) >= 64'(MIN_LAP_CYCLES));

    // Lap FSM next-state and result computation.
    always_comb begin
        state_nxt_s        = state_r;
        timer_nxt_s        = timer_r;
        round_pulse_nxt_s  = 1'b0;
        lap_valid_nxt_s    = 1'b0;
        lap_time_nxt_s     = lap_time_r;
        lap_count_nxt_s    = lap_count_r;
        lap_overflow_nxt_s = lap_overflow_r;

        if (lap_clear) begin
            // A coincident round edge is deliberately dropped here.
            state_nxt_s        = WAIT_FIRST;
            timer_nxt_s        = {LAP_W{1'b0}};
            lap_time_nxt_s     = {LAP_W{1'b0}};
            lap_count_nxt_s    = {CNT_W{1'b0}};
            lap_overflow_nxt_s = 1'b0;
        end else begin
            case (state_r)
                WAIT_FIRST: begin
                    if (round_edge_s) begin
                        state_nxt_s       = TIMING;
                        timer_nxt_s       = {LAP_W{1'b0}};
                        round_pulse_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT_FIRST;
                    end
                end
                TIMING: begin
                    if (round_edge_s && lap_long_s) begin
                        round_pulse_nxt_s  = 1'b1;
                        lap_valid_nxt_s    = 1'b1;
                        lap_time_nxt_s     = elapsed_s;
                        lap_count_nxt_s    = lap_count_r + CNT_W'(1'b1);
                        lap_overflow_nxt_s = lap_overflow_r | saturated_s;
                        timer_nxt_s        = {LAP_W{1'b0}};
                    end else begin
                        // Short edges are lockout noise: the timer keeps running.
                        timer_nxt_s = elapsed_s;
                    end
                end
                default: begin
                    state_nxt_s = WAIT_FIRST;
                    timer_nxt_s = {LAP_W{1'b0}};
                end
            endcase
        end
    end

    // State, timer and all output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= WAIT_FIRST;
            timer_r        <= {LAP_W{1'b0}};
            sensorsignal_r <= 1'b0;
            roundsignal_r  <= 1'b0;
            round_pulse_r  <= 1'b0;
            lap_valid_r    <= 1'b0;
            lap_time_r     <= {LAP_W{1'b0}};
            lap_count_r    <= {CNT_W{1'b0}};
            lap_overflow_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            timer_r        <= timer_nxt_s;
            sensorsignal_r <= seg_level_s;
            roundsignal_r  <= round_level_s;
            round_pulse_r  <= round_pulse_nxt_s;
            lap_valid_r    <= lap_valid_nxt_s;
            lap_time_r     <= lap_time_nxt_s;
            lap_count_r    <= lap_count_nxt_s;
            lap_overflow_r <= lap_overflow_nxt_s;
        end
    end

    assign sensorsignal = sensorsignal_r;
    assign roundsignal  = roundsignal_r;
    assign round_pulse  = round_pulse_r;
    assign lap_valid    = lap_valid_r;
    assign lap_time     = lap_time_r;
    assign lap_count    = lap_count_r;
    assign lap_overflow = lap_overflow_r;

endmodule

// File: tb/tb_track_sensor_conditioner.sv
// Self-checking bench for track_sensor_conditioner (DEBOUNCE=4, MIN_LAP=20,
// LAP_W=8, CNT_W=4): hand sequences for reset/debounce/async reset, a table of
// lap scenarios, and a randomized run against an event-level reference model.
module tb_track_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int MINL = 20;
    localparam int LW   = 8;
    localparam int CW   = 4;
    localparam int RN   = 3000;
    localparam int TMAX = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          seg_n = 1'b0;
    logic          round_n = 1'b0;
    logic          lap_clear = 1'b0;
    logic          sensorsignal;
    logic          roundsignal;
    logic          round_pulse;
    logic          lap_valid;
    logic [LW-1:0] lap_time;
    logic [CW-1:0] lap_count;
    logic          lap_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int gap;        // edges from this press start to the next press start
        bit clr_pre;    // one lap_clear cycle before the press
        int clr_at;     // window index whose edge sees lap_clear (-1: none)
        int pulses;
        int valids;
        int time_exp;
        int count_exp;
        bit ovf_exp;
    } row_t;

    row_t rows[28];

    bit rraw[2][RN];
    bit lvl[2][RN];
    bit clr_a[RN];
    bit e_pulse[RN];
    bit e_valid[RN];
    bit e_ovf[RN];
    int e_time[RN];
    int e_count[RN];

    track_sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .MIN_LAP_CYCLES  (MINL),
        .LAP_W           (LW),
        .CNT_W           (CW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .seg_sensor_raw_n   (seg_n),
        .round_sensor_raw_n (round_n),
        .lap_clear          (lap_clear),
        .sensorsignal       (sensorsignal),
        .roundsignal        (roundsignal),
        .round_pulse        (round_pulse),
        .lap_valid          (lap_valid),
        .lap_time           (lap_time),
        .lap_count          (lap_count),
        .lap_overflow       (lap_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " sensorsignal"}, 32'(sensorsignal), 0);
        check({tag, " roundsignal"},  32'(roundsignal),  0);
        check({tag, " round_pulse"},  32'(round_pulse),  0);
        check({tag, " lap_valid"},    32'(lap_valid),    0);
        check({tag, " lap_time"},     32'(lap_time),     0);
        check({tag, " lap_count"},    32'(lap_count),    0);
        check({tag, " lap_overflow"}, 32'(lap_overflow), 0);
    endtask

    // One press of the start/finish sensor: low for 5 samples, then high.
    task automatic apply_row(input int idx, input row_t r);
        int pulses = 0;
        int valids = 0;
        if (r.clr_pre) begin
            lap_clear = 1'b1;
            @(posedge clk); #1;
            lap_clear = 1'b0;
        end
        round_n = 1'b0;
        for (int j = 0; j < r.gap; j++) begin
            if (j == 5) round_n = 1'b1;
            lap_clear = (j == r.clr_at);
            @(posedge clk); #1;
            pulses += int'(round_pulse);
            valids += int'(lap_valid);
            if (j == r.clr_at)
                check($sformatf("row%0d roundsignal_at_clear", idx), 32'(roundsignal), 1);
        end
        lap_clear = 1'b0;
        check($sformatf("row%0d round_pulses", idx), pulses, r.pulses);
        check($sformatf("row%0d lap_valids", idx), valids, r.valids);
        check($sformatf("row%0d lap_time", idx), 32'(lap_time), r.time_exp);
        check($sformatf("row%0d lap_count", idx), 32'(lap_count), r.count_exp);
        check($sformatf("row%0d lap_overflow", idx), 32'(lap_overflow), 32'(r.ovf_exp));
    endtask

    initial begin
        int idx, len, rsel, s, e, tref, lt, lc;
        bit lv, outl, st, ov, rise;

        // Lap scenario table: gap, clr_pre, clr_at, pulses, valids, time, count, ovf
        rows[0]  = '{50,  1'b1, -1, 1, 0, 0,   0, 1'b0};  // arm only
        rows[1]  = '{37,  1'b0, -1, 1, 1, 50,  1, 1'b0};
        rows[2]  = '{10,  1'b0, -1, 1, 1, 37,  2, 1'b0};
        rows[3]  = '{50,  1'b0, -1, 0, 0, 37,  2, 1'b0};  // 10 after accepted: locked out
        rows[4]  = '{300, 1'b0, -1, 1, 1, 60,  3, 1'b0};
        rows[5]  = '{40,  1'b0, -1, 1, 1, 255, 4, 1'b1};  // 300-cycle lap saturates
        rows[6]  = '{30,  1'b0, -1, 1, 1, 40,  5, 1'b1};  // overflow sticky
        rows[7]  = '{25,  1'b1, -1, 1, 0, 0,   0, 1'b0};  // clear, re-arm
        for (int i = 8; i < 25; i++)
            rows[i] = '{25, 1'b0, -1, 1, 1, 25, (i - 7) % 16, 1'b0};  // 17 laps wrap to 1
        rows[25] = '{30,  1'b0, 6,  0, 0, 0,   0, 1'b0};  // clear coincident with edge
        rows[26] = '{30,  1'b0, -1, 1, 0, 0,   0, 1'b0};  // only re-arms
        rows[27] = '{30,  1'b0, -1, 1, 1, 30,  1, 1'b0};

        // 1. Reset state with raw inputs active, then release and time the first edge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        reset_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            check($sformatf("rel t%0d roundsignal", t), 32'(roundsignal), 32'(t >= 6));
            check($sformatf("rel t%0d sensorsignal", t), 32'(sensorsignal), 32'(t >= 6));
            check($sformatf("rel t%0d round_pulse", t), 32'(round_pulse), 32'(t == 6));
            check($sformatf("rel t%0d lap_valid", t), 32'(lap_valid), 0);
        end
        round_n = 1'b1;
        seg_n   = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("idle sensorsignal", 32'(sensorsignal), 0);

        // 2. Debounce: 3-sample glitches are rejected, a long hold is accepted.
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 6; j++) begin
                seg_n = (j >= 3);
                @(posedge clk); #1;
                check($sformatf("glitch%0d.%0d sensorsignal", g, j), 32'(sensorsignal), 0);
            end
        end
        for (int t = 0; t < 10; t++) begin
            seg_n = 1'b0;
            @(posedge clk); #1;
            check($sformatf("hold t%0d sensorsignal", t), 32'(sensorsignal), 32'(t >= 6));
        end
        seg_n = 1'b1;

        // 3-6. Lap table: measurement, lockout, saturation, wrap, clear.
        for (int i = 0; i < 28; i++) apply_row(i, rows[i]);

        // Async reset in the middle of a lap with a car present.
        round_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_async roundsignal", 32'(roundsignal), 1);
        check("pre_async lap_count", 32'(lap_count), 2);
        check("pre_async lap_time", 32'(lap_time), 30);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");

        // Randomized run: build raw streams as segments of random length.
        for (int ch = 0; ch < 2; ch++) begin
            idx = 0;
            lv  = 1'b1;
            while (idx < RN) begin
                rsel = $urandom_range(0, 9);
                if (rsel < 4) len = $urandom_range(1, 3);
                else if (rsel < 9) len = $urandom_range(4, 60);
                else len = $urandom_range(100, 320);
                for (int k = 0; k < len && idx < RN; k++) begin
                    rraw[ch][idx] = lv;
                    idx++;
                end
                lv = ~lv;
            end
        end
        for (int t = 0; t < RN; t++) clr_a[t] = ($urandom_range(0, 299) == 0);

        // Debounced levels: a run of >= DEB samples opposite to the current
        // output changes it, visible DEB+2 edges after the run's first sample.
        for (int ch = 0; ch < 2; ch++) begin
            for (int t = 0; t < RN; t++) lvl[ch][t] = 1'b0;
            outl = 1'b0;
            s = 0;
            while (s < RN) begin
                e = s;
                while (e + 1 < RN && rraw[ch][e + 1] == rraw[ch][s]) e++;
                if ((!rraw[ch][s]) != outl && (e - s + 1) >= DEB) begin
                    outl = !rraw[ch][s];
                    for (int k = s + DEB + 2; k < RN; k++) lvl[ch][k] = outl;
                end
                s = e + 1;
            end
        end

        // Lap results from the times of rising roundsignal edges.
        st = 1'b0; tref = 0; lt = 0; lc = 0; ov = 1'b0;
        for (int t = 0; t < RN; t++) begin
            e_pulse[t] = 1'b0;
            e_valid[t] = 1'b0;
            rise = lvl[1][t] && ((t > 0) ? !lvl[1][t - 1] : 1'b1);
            if (clr_a[t]) begin
                st = 1'b0; lt = 0; lc = 0; ov = 1'b0;
            end else if (rise && !st) begin
                st = 1'b1; tref = t; e_pulse[t] = 1'b1;
            end else if (rise && (t - tref) >= MINL) begin
                e_pulse[t] = 1'b1;
                e_valid[t] = 1'b1;
                lt = ((t - tref) > TMAX) ? TMAX : (t - tref);
                ov = ov | ((t - tref) > TMAX);
                lc = (lc + 1) % (1 << CW);
                tref = t;
            end
            e_time[t]  = lt;
            e_count[t] = lc;
            e_ovf[t]   = ov;
        end

        round_n   = 1'b1;
        seg_n     = 1'b1;
        lap_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < RN; t++) begin
            seg_n     = rraw[0][t];
            round_n   = rraw[1][t];
            lap_clear = clr_a[t];
            @(posedge clk); #1;
            check($sformatf("rnd%0d sensorsignal", t), 32'(sensorsignal), 32'(lvl[0][t]));
            check($sformatf("rnd%0d roundsignal", t), 32'(roundsignal), 32'(lvl[1][t]));
            check($sformatf("rnd%0d round_pulse", t), 32'(round_pulse), 32'(e_pulse[t]));
            check($sformatf("rnd%0d lap_valid", t), 32'(lap_valid), 32'(e_valid[t]));
            check($sformatf("rnd%0d lap_time", t), 32'(lap_time), e_time[t]);
            check($sformatf("rnd%0d lap_count", t), 32'(lap_count), e_count[t]);
            check($sformatf("rnd%0d lap_overflow", t), 32'(lap_overflow), 32'(e_ovf[t]));
        end
        lap_clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
